pll_lock_supervisor: RTL
========================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: cycles pll_rst is held high per reset attempt (range 1..65535).
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 50000: maximum cycles to wait for lock per attempt (1 ms at 50 MHz; range 1..2^20-1).
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: cycles the synchronized lock must stay high before release (range 1..65535).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: consecutive timed-out attempts before entering FAIL (range 1..15).
REQ-005 SHALL have port refclk, input, 1: the single 50 MHz reference clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port pll_locked, input, 1: PLL locked indication, asynchronous to refclk.
REQ-008 SHALL have port restart, input, 1: synchronous single-cycle request to re-run the full PLL bring-up.
REQ-009 SHALL have port pll_rst, output, 1: drives the PLL rst input; high means the PLL is held in reset.
REQ-010 SHALL have port sys_rst, output, 1: active-high reset for the outclk_0 (148 MHz) pixel-domain logic.
REQ-011 SHALL have port ready, output, 1: high only in state RUN.
REQ-012 SHALL have port fail, output, 1: high only in state FAIL.
REQ-013 SHALL have port retry_cnt, output, 4: number of timed-out attempts since the last successful lock or restart.
REQ-014 SHALL have port lock_loss_cnt, output, 8: lock-loss events counted in RUN; present only when PLL_SUP_STATUS_CNT_EN is defined.

Function
REQ-015 SHALL pass pll_locked through a 2-flop synchronizer (locked_s, reset value 0) and use only locked_s internally, giving 2 cycles of latency.
REQ-016 SHALL implement the states RST_PLL, WAIT_LOCK, STABLE, RUN and FAIL, with one shared cycle counter sized to the largest parameter.
REQ-017 SHALL, in RST_PLL, drive pll_rst=1 and sys_rst=1, then move to WAIT_LOCK with counter cleared after exactly PLL_RST_CYCLES cycles.
REQ-018 SHALL, in WAIT_LOCK, drive pll_rst=0 and sys_rst=1, and move to STABLE with counter cleared on locked_s=1.
REQ-019 SHALL, in WAIT_LOCK, treat LOCK_TIMEOUT_CYCLES elapsed with locked_s=0 as a timeout: increment retry_cnt, then go to FAIL if the new value equals MAX_RETRIES, otherwise to RST_PLL.
REQ-020 SHALL, in STABLE, return to WAIT_LOCK with the timeout counter restarted if locked_s drops; retry_cnt is unchanged.
REQ-021 SHALL, in STABLE, move to RUN after locked_s has been high for LOCK_STABLE_CYCLES consecutive cycles, and clear retry_cnt on that transition.
REQ-022 SHALL, in RUN, drive sys_rst=0, ready=1 and pll_rst=0.
REQ-023 SHALL, when locked_s=0 in RUN, assert sys_rst and deassert ready in the next cycle, then go to RST_PLL; retry_cnt is unchanged.
REQ-024 SHALL, in FAIL, hold pll_rst=1, sys_rst=1 and fail=1 indefinitely; the only exits are restart or rst.
REQ-025 SHALL make restart=1 in any state force RST_PLL on the next cycle, clear retry_cnt and reset the counter; restart has priority over every other transition.
REQ-026 SHALL register all outputs so they are glitch-free, with no combinational path from pll_locked to any output.
REQ-027 SHALL never deassert sys_rst in any state other than RUN.

Reset
REQ-028 SHALL, while rst=1, asynchronously force state RST_PLL, counter=0, locked_s=0, pll_rst=1, sys_rst=1, ready=0, fail=0, retry_cnt=0 and lock_loss_cnt=0.
REQ-029 SHALL, on rst deassertion mid-operation, restart the bring-up sequence from RST_PLL with a full PLL_RST_CYCLES period.

Configuration
REQ-030 SHALL, with PLL_SUP_STATUS_CNT_EN defined, increment lock_loss_cnt on each RUN-to-RST_PLL transition caused by loss of lock (including one coinciding with restart), saturating at 255 and cleared only by rst.
REQ-031 SHALL, with PLL_SUP_STATUS_CNT_EN undefined, omit the lock_loss_cnt port and its logic entirely; all other behaviour is identical.

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=3)
REQ-032 SHALL cover normal bring-up: release rst, assert pll_locked at cycle 10 -> pll_rst falls at cycle 4, sys_rst falls and ready rises 2+8 cycles after pll_locked rises, retry_cnt=0.
REQ-033 SHALL cover retry exhaustion: pll_locked held 0 -> retry_cnt steps 1, 2, 3 at roughly 36-cycle intervals, then fail=1 and pll_rst=1 held; a restart pulse -> retry_cnt=0, fail=0, new attempt.
REQ-034 SHALL cover a lock glitch in STABLE: pll_locked drops for 1 cycle after 5 stable cycles -> no RUN entry, and a further 8 stable cycles are required before ready=1.
REQ-035 SHALL cover lock loss in RUN: drop pll_locked -> sys_rst=1 and ready=0 by 3 cycles after the drop, pll_rst=1 for 4 cycles, lock_loss_cnt=1 when the macro is defined.
REQ-036 SHALL cover restart coinciding with lock loss in RUN: -> RST_PLL next cycle, retry_cnt=0, lock_loss_cnt incremented exactly once.
REQ-037 SHALL cover asynchronous rst mid-STABLE: -> all outputs at reset values immediately, without waiting for a refclk edge.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: sequences PLL reset, lock qualification and pixel-domain reset release.
// Optional lock-loss counter port and logic are built when PLL_SUP_STATUS_CNT_EN is defined.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt
`ifdef PLL_SUP_STATUS_CNT_EN
    ,
    output logic [7:0] lock_loss_cnt
`endif
);

    localparam int MAX_AB     = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYCLES = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    // The WAIT_LOCK cycle that first sees lock counts as the first stable cycle.
    localparam int STABLE_MIN = (LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_MIN);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RST_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             sync_q;
    logic             locked_s_q;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        if (restart) begin
            state_d = RST_PLL;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                RST_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s_q) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_d = retry_q + 4'd1;
                        cnt_d   = '0;
                        state_d = (retry_d == RETRY_LIMIT) ? FAIL : RST_PLL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!locked_s_q) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!locked_s_q) begin
                        state_d = RST_PLL;
                        cnt_d   = '0;
                    end
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = RST_PLL;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs follow the next state so they change in step with it from a flop.
        pll_rst_d = (state_d == RST_PLL) || (state_d == FAIL);
        sys_rst_d = (state_d != RUN);
        ready_d   = (state_d == RUN);
        fail_d    = (state_d == FAIL);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q    <= RST_PLL;
            cnt_q      <= '0;
            retry_q    <= '0;
            sync_q     <= 1'b0;
            locked_s_q <= 1'b0;
            pll_rst_q  <= 1'b1;
            sys_rst_q  <= 1'b1;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            sync_q     <= pll_locked;
            locked_s_q <= sync_q;
            pll_rst_q  <= pll_rst_d;
            sys_rst_q  <= sys_rst_d;
            ready_q    <= ready_d;
            fail_q     <= fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

`ifdef PLL_SUP_STATUS_CNT_EN
    // A lock loss seen in RUN is counted even when restart arrives in the same cycle.
    logic       lock_lost;
    logic [7:0] lock_loss_q, lock_loss_d;

    always_comb begin
        lock_lost   = (state_q == RUN) && !locked_s_q;
        lock_loss_d = lock_loss_q;
        if (lock_lost && (lock_loss_q != 8'hFF)) begin
            lock_loss_d = lock_loss_q + 8'd1;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_loss_q <= 8'd0;
        end else begin
            lock_loss_q <= lock_loss_d;
        end
    end

    assign lock_loss_cnt = lock_loss_q;
`endif

endmodule
